// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter: shares one physical memory port between the instruction
// fetch requester and the data (load/store) requester.
// Optional feature macro: LC3B_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration on ties. When it is not defined, the data port has fixed priority.

package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;
endpackage

module lc3b_mem_arbiter
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          rst_n,

  input  logic          inst_read,
  input  logic          inst_write,
  input  lc3b_word      inst_address,
  input  lc3b_word      inst_wdata,
  input  lc3b_mem_wmask inst_byte_enable,
  output logic          inst_resp,
  output lc3b_word      inst_rdata,

  input  logic          data_read,
  input  logic          data_write,
  input  lc3b_word      data_address,
  input  lc3b_word      data_wdata,
  input  lc3b_mem_wmask data_byte_enable,
  output logic          data_resp,
  output lc3b_word      data_rdata,

  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  output lc3b_mem_wmask pmem_byte_enable,
  input  logic          pmem_resp,
  input  lc3b_word      pmem_rdata,

  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t        state;
  logic          cmd_read;
  logic          cmd_write;
  lc3b_word      cmd_address;
  lc3b_word      cmd_wdata;
  lc3b_mem_wmask cmd_mask;

  logic          inst_req;
  logic          data_req;
  logic          pick_data;

`ifdef LC3B_ARB_ROUND_ROBIN_EN
  logic          last_grant_data;
`endif

  assign inst_req = inst_read | inst_write;
  assign data_req = data_read | data_write;

  // Arbitration: choose which requester wins if the FSM grants this cycle.
  always_comb begin
    pick_data = 1'b0;
`ifdef LC3B_ARB_ROUND_ROBIN_EN
    // Data wins when alone, or on a tie when instruction was granted last.
    pick_data = data_req & (~inst_req | ~last_grant_data);
`else
    pick_data = data_req;
`endif
  end

  // Grant FSM and command registers; the command registers return to their
  // reset values on completion, so the pmem outputs read as idle values in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_read    <= 1'b0;
      cmd_write   <= 1'b0;
      cmd_address <= '0;
      cmd_wdata   <= '0;
      cmd_mask    <= '1;
`ifdef LC3B_ARB_ROUND_ROBIN_EN
      last_grant_data <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (inst_req | data_req) begin
            if (pick_data) begin
              state       <= GRANT_D;
              cmd_read    <= data_read;
              cmd_write   <= data_write & ~data_read;
              cmd_address <= data_address;
              cmd_wdata   <= data_wdata;
              cmd_mask    <= data_byte_enable;
            end else begin
              state       <= GRANT_I;
              cmd_read    <= inst_read;
              cmd_write   <= inst_write & ~inst_read;
              cmd_address <= inst_address;
              cmd_wdata   <= inst_wdata;
              cmd_mask    <= inst_byte_enable;
            end
`ifdef LC3B_ARB_ROUND_ROBIN_EN
            last_grant_data <= pick_data;
`endif
          end
        end
        GRANT_I, GRANT_D: begin
          if (pmem_resp) begin
            state       <= IDLE;
            cmd_read    <= 1'b0;
            cmd_write   <= 1'b0;
            cmd_address <= '0;
            cmd_wdata   <= '0;
            cmd_mask    <= '1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign pmem_read        = cmd_read;
  assign pmem_write       = cmd_write;
  assign pmem_address     = cmd_address;
  assign pmem_wdata       = cmd_wdata;
  assign pmem_byte_enable = cmd_mask;

  assign inst_resp  = (state == GRANT_I) & pmem_resp;
  assign data_resp  = (state == GRANT_D) & pmem_resp;
  assign inst_rdata = pmem_rdata;
  assign data_rdata = pmem_rdata;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Self-checking bench for lc3b_mem_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked against a transaction-level model.
module tb_lc3b_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        inst_read, inst_write;
  logic [15:0] inst_address, inst_wdata;
  logic [1:0]  inst_byte_enable;
  logic        inst_resp;
  logic [15:0] inst_rdata;
  logic        data_read, data_write;
  logic [15:0] data_address, data_wdata;
  logic [1:0]  data_byte_enable;
  logic        data_resp;
  logic [15:0] data_rdata;
  logic        pmem_read, pmem_write;
  logic [15:0] pmem_address, pmem_wdata;
  logic [1:0]  pmem_byte_enable;
  logic        pmem_resp;
  logic [15:0] pmem_rdata;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  lc3b_mem_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .inst_read        (inst_read),
    .inst_write       (inst_write),
    .inst_address     (inst_address),
    .inst_wdata       (inst_wdata),
    .inst_byte_enable (inst_byte_enable),
    .inst_resp        (inst_resp),
    .inst_rdata       (inst_rdata),
    .data_read        (data_read),
    .data_write       (data_write),
    .data_address     (data_address),
    .data_wdata       (data_wdata),
    .data_byte_enable (data_byte_enable),
    .data_resp        (data_resp),
    .data_rdata       (data_rdata),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_address     (pmem_address),
    .pmem_wdata       (pmem_wdata),
    .pmem_byte_enable (pmem_byte_enable),
    .pmem_resp        (pmem_resp),
    .pmem_rdata       (pmem_rdata),
    .busy             (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the memory port (0 none, 1 inst, 2 data)
  // and the command it captured when it won.
  int          m_owner;
  int          m_last;
  logic        m_rd, m_wr;
  logic [15:0] m_addr, m_wd;
  logic [1:0]  m_be;

  function automatic int winner(input logic ir, input logic dr, input int last);
`ifdef LC3B_ARB_ROUND_ROBIN_EN
    if (ir && dr) return (last == 2) ? 1 : 2;
    if (ir) return 1;
    if (dr) return 2;
    return 0;
`else
    if (dr) return 2;
    if (ir) return 1;
    return 0;
`endif
  endfunction

  // Model update on the clock edge (or asynchronously on reset).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= 0;
      m_last  <= 2;
    end else if (m_owner != 0) begin
      if (pmem_resp) m_owner <= 0;
    end else begin
      case (winner(inst_read | inst_write, data_read | data_write, m_last))
        1: begin
          m_owner <= 1; m_last <= 1;
          m_rd <= inst_read; m_wr <= inst_write & ~inst_read;
          m_addr <= inst_address; m_wd <= inst_wdata; m_be <= inst_byte_enable;
        end
        2: begin
          m_owner <= 2; m_last <= 2;
          m_rd <= data_read; m_wr <= data_write & ~data_read;
          m_addr <= data_address; m_wd <= data_wdata; m_be <= data_byte_enable;
        end
        default: ;
      endcase
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    #2;
    if (m_owner == 0) begin
      chk("m_pmem_read", {31'd0, pmem_read}, 32'd0);
      chk("m_pmem_write", {31'd0, pmem_write}, 32'd0);
      chk("m_pmem_address", {16'd0, pmem_address}, 32'h0);
      chk("m_pmem_wdata", {16'd0, pmem_wdata}, 32'h0);
      chk("m_pmem_be", {30'd0, pmem_byte_enable}, 32'h3);
      chk("m_busy", {31'd0, busy}, 32'd0);
    end else begin
      chk("m_pmem_read", {31'd0, pmem_read}, {31'd0, m_rd});
      chk("m_pmem_write", {31'd0, pmem_write}, {31'd0, m_wr});
      chk("m_pmem_address", {16'd0, pmem_address}, {16'd0, m_addr});
      chk("m_pmem_wdata", {16'd0, pmem_wdata}, {16'd0, m_wd});
      chk("m_pmem_be", {30'd0, pmem_byte_enable}, {30'd0, m_be});
      chk("m_busy", {31'd0, busy}, 32'd1);
    end
    chk("m_inst_resp", {31'd0, inst_resp}, {31'd0, (m_owner == 1) && pmem_resp});
    chk("m_data_resp", {31'd0, data_resp}, {31'd0, (m_owner == 2) && pmem_resp});
    chk("m_inst_rdata", {16'd0, inst_rdata}, {16'd0, pmem_rdata});
    chk("m_data_rdata", {16'd0, data_rdata}, {16'd0, pmem_rdata});
  end

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic idle_inputs();
    inst_read = 0; inst_write = 0; inst_address = '0; inst_wdata = '0; inst_byte_enable = '1;
    data_read = 0; data_write = 0; data_address = '0; data_wdata = '0; data_byte_enable = '1;
    pmem_resp = 0;
  endtask

  logic [15:0] order_exp [4];
  logic [15:0] first_exp;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    pmem_rdata = 16'h0;

    // Reset with both ports requesting.
    inst_read = 1; inst_address = 16'h1111;
    data_read = 1; data_address = 16'h2222;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pmem_read", {31'd0, pmem_read}, 32'd0);
    chk("rst_pmem_be", {30'd0, pmem_byte_enable}, 32'h3);
    chk("rst_resp", {30'd0, inst_resp, data_resp}, 32'd0);
    rst_n = 1'b1;
    tick();
`ifdef LC3B_ARB_ROUND_ROBIN_EN
    first_exp = 16'h1111;
`else
    first_exp = 16'h2222;
`endif
    chk("rel_pmem_read", {31'd0, pmem_read}, 32'd1);
    chk("rel_first_addr", {16'd0, pmem_address}, {16'd0, first_exp});
    inst_read = 0; data_read = 0; pmem_resp = 1;
    tick();
    pmem_resp = 0;
    tick();

    // Single fetch: request at cycle 0, memory answers at cycle 3.
    inst_read = 1; inst_address = 16'h3000;
    tick();
    chk("fetch_pmem_read", {31'd0, pmem_read}, 32'd1);
    chk("fetch_addr", {16'd0, pmem_address}, 32'h3000);
    tick();
    tick();
    pmem_resp = 1; pmem_rdata = 16'h1234;
    #1;
    chk("fetch_inst_resp", {31'd0, inst_resp}, 32'd1);
    chk("fetch_inst_rdata", {16'd0, inst_rdata}, 32'h1234);
    chk("fetch_data_resp", {31'd0, data_resp}, 32'd0);
    tick();
    pmem_resp = 0; inst_read = 0;
    chk("fetch_idle", {31'd0, busy}, 32'd0);
    tick();

    // Byte store; mid-grant input changes must not leak through.
    data_write = 1; data_address = 16'h4001; data_wdata = 16'hAB00; data_byte_enable = 2'b10;
    tick();
    chk("st_write", {30'd0, pmem_write, pmem_read}, 32'h2);
    chk("st_addr", {16'd0, pmem_address}, 32'h4001);
    chk("st_wdata", {16'd0, pmem_wdata}, 32'hAB00);
    chk("st_be", {30'd0, pmem_byte_enable}, 32'h2);
    data_byte_enable = 2'b11; data_address = 16'hFFFF;
    tick();
    chk("st_be_held", {30'd0, pmem_byte_enable}, 32'h2);
    chk("st_addr_held", {16'd0, pmem_address}, 32'h4001);
    pmem_resp = 1;
    #1;
    chk("st_resp", {30'd0, inst_resp, data_resp}, 32'h1);
    tick();
    pmem_resp = 0; data_write = 0;
    tick();

    // Contention: both ports hold requests for four transactions.
    inst_read = 1; inst_address = 16'hA000;
    data_read = 1; data_address = 16'hD000;
`ifdef LC3B_ARB_ROUND_ROBIN_EN
    order_exp[0] = 16'hA000; order_exp[1] = 16'hD000; order_exp[2] = 16'hA000; order_exp[3] = 16'hD000;
`else
    order_exp[0] = 16'hD000; order_exp[1] = 16'hD000; order_exp[2] = 16'hD000; order_exp[3] = 16'hD000;
`endif
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("order_%0d", i), {16'd0, pmem_address}, {16'd0, order_exp[i]});
      pmem_resp = 1;
      tick();
      pmem_resp = 0;
      chk($sformatf("order_gap_%0d", i), {31'd0, busy}, 32'd0);
    end
    inst_read = 0; data_read = 0;
    tick();
    tick();

    // Reset during a data grant, late pmem_resp after release.
    data_write = 1; data_address = 16'h5555; data_wdata = 16'h7777;
    tick();
    chk("mr_busy", {31'd0, busy}, 32'd1);
    data_write = 0;
    rst_n = 0;
    #1;
    chk("mr_pmem_write", {31'd0, pmem_write}, 32'd0);
    chk("mr_pmem_addr", {16'd0, pmem_address}, 32'h0);
    chk("mr_busy_rst", {31'd0, busy}, 32'd0);
    tick();
    rst_n = 1;
    tick();
    pmem_resp = 1;
    #1;
    chk("mr_late_resp", {30'd0, inst_resp, data_resp}, 32'd0);
    tick();
    pmem_resp = 0;
    inst_read = 1; inst_address = 16'h6000;
    tick();
    chk("mr_clean_grant", {15'd0, pmem_read, pmem_address}, 32'h16000);
    pmem_resp = 1; inst_read = 0;
    tick();
    pmem_resp = 0;
    tick();

    // Randomized traffic, including random resets and stray pmem_resp.
    for (int c = 0; c < 1500; c++) begin
      rst_n            = ($urandom_range(149) != 0);
      inst_read        = ($urandom_range(3) == 0);
      inst_write       = ($urandom_range(3) == 0);
      inst_address     = 16'($urandom);
      inst_wdata       = 16'($urandom);
      inst_byte_enable = 2'($urandom);
      data_read        = ($urandom_range(3) == 0);
      data_write       = ($urandom_range(3) == 0);
      data_address     = 16'($urandom);
      data_wdata       = 16'($urandom);
      data_byte_enable = 2'($urandom);
      pmem_resp        = ($urandom_range(2) == 0);
      pmem_rdata       = 16'($urandom);
      tick();
    end

    rst_n = 1;
    idle_inputs();
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3b_mem_arbiter.md
# lc3b_mem_arbiter

Two-port memory arbiter that shares the single physical memory port between the instruction-fetch requester and the data (load/store) requester of the LC-3b multicycle datapath. It sits between the control/datapath pair and main memory. It captures the winning requester's command, drives it to memory until completion, and routes the response back to the winner only.

## Interface
Parameters:
- none; all widths come from `lc3b_types` (word = 16 bits, byte mask = 2 bits).

Ports:
- `clk` in 1: the single clock. Reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous, active-low reset.
- `inst_read` in 1: instruction port read request, held until `inst_resp`.
- `inst_write` in 1: instruction port write request, held until `inst_resp`.
- `inst_address` in 16: instruction port byte address.
- `inst_wdata` in 16: instruction port write data.
- `inst_byte_enable` in 2: instruction port write mask.
- `inst_resp` out 1: one-cycle completion pulse to the instruction port.
- `inst_rdata` out 16: read data to the instruction port.
- `data_read`, `data_write`, `data_address`, `data_wdata`, `data_byte_enable`, `data_resp`, `data_rdata`: same as the `inst_*` set, for the data port.
- `pmem_read` out 1: physical memory read strobe.
- `pmem_write` out 1: physical memory write strobe.
- `pmem_address` out 16: physical memory address.
- `pmem_wdata` out 16: physical memory write data.
- `pmem_byte_enable` out 2: physical memory write mask.
- `pmem_resp` in 1: physical memory completion pulse.
- `pmem_rdata` in 16: physical memory read data.
- `busy` out 1: high while a grant is active.

## Operation
- FSM states: `IDLE`, `GRANT_I`, `GRANT_D`.
- In `IDLE`, a port requests when `read|write` is high. The winner is chosen by the arbitration rule (see Configuration).
- On the grant edge, the winner's command (op, address, wdata, mask) is latched into command registers. Later changes on the requester inputs are ignored until completion.
- If a requester drives `read` and `write` together, the arbiter captures a read (`write` is dropped).
- In `GRANT_x`, `pmem_*` are driven from the command registers.
- In `GRANT_x`, `x_resp = pmem_resp` (combinational).
- `x_rdata = pmem_rdata` in all states for both ports, unregistered. Requesters qualify it with their own `resp`.
- The non-granted port's `resp` is 0.
- On `pmem_resp` in `GRANT_x`, the FSM returns to `IDLE` unconditionally.
- `IDLE` lasts at least one cycle after each completion. This gives the requester FSM the edge it needs to drop or change its request, so a stale request is never re-granted.
- `pmem_resp` while in `IDLE` is ignored (no `resp` to either port).
- A requester that drops its request mid-grant does not cancel the transaction: the arbiter holds `pmem_*` until `pmem_resp`.
- `busy = (state != IDLE)`.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state becomes `IDLE`.
  - command registers clear: op = none, address = 0x0000, wdata = 0x0000, mask = 2'b11.
  - `last_grant` becomes data, so the instruction port wins the first tie under round-robin.
- Outputs while in reset and in `IDLE`:
  - `pmem_read` = `pmem_write` = 0.
  - `pmem_address` = 0x0000, `pmem_wdata` = 0x0000, `pmem_byte_enable` = 2'b11.
  - `inst_resp` = `data_resp` = 0.
  - `busy` = 0.
- Reset asserted mid-grant abandons the memory transaction. A late `pmem_resp` arriving after reset release is ignored in `IDLE`.
- Cycle accounting:
  - request seen in `IDLE` at cycle N → `pmem_read`/`pmem_write` high at N+1.
  - `x_resp` coincides with `pmem_resp` at cycle M.
  - `IDLE` at M+1.
  - earliest next grant strobe at M+2.
- Minimum transaction time is 3 cycles, assuming single-cycle memory response.

## Configuration
- `LC3B_ARB_ROUND_ROBIN_EN` defined:
  - simultaneous requests in `IDLE` go to the port not granted last.
  - `last_grant` updates on every grant.
  - a lone requester always wins.
- `LC3B_ARB_ROUND_ROBIN_EN` undefined:
  - fixed priority, data port over instruction port.
  - `last_grant` is not implemented.
  - the instruction port can starve only while the data port requests continuously.

## Test plan
- **Reset:** hold `rst_n`=0 with both ports requesting → all `pmem_*` at reset values, both `resp`=0, `busy`=0. Release → grant strobe on the following cycle.
- **Single fetch:** `inst_read`=1, `inst_address`=0x3000 at cycle 0 → `pmem_read`=1 and `pmem_address`=0x3000 at cycle 1. Memory returns `pmem_resp`=1, `pmem_rdata`=0x1234 at cycle 3 → `inst_resp`=1 with `inst_rdata`=0x1234 at cycle 3, `data_resp`=0, `IDLE` at cycle 4.
- **Byte store:** `data_write`=1, `data_address`=0x4001, `data_wdata`=0xAB00, mask 2'b10 → `pmem_write`=1 with exactly those values until `pmem_resp`. `data_byte_enable` changed to 2'b11 mid-grant is not reflected.
- **Contention, macro undefined:** both ports request at cycle 0 → data granted at cycle 1. Instruction port granted on the second cycle after data `pmem_resp`.
- **Contention, macro defined:** both ports request continuously for four transactions → grant order inst, data, inst, data.
- **Reset mid-grant:** pull `rst_n` low during `GRANT_D` with a `pmem_resp` pulse arriving after release → `pmem_*` return to reset values immediately, no `data_resp` is issued, and the next grant is clean.
